// File: rtl/dm_wb_pkg.sv
// Shared types and defaults for the data-memory write buffer.
// Entries hold a word address (byte address without [1:0]) and a data word.
package dm_wb_pkg;

    localparam int unsigned DmWbDepth = 4;
    localparam int unsigned DmWbAw    = 32;
    localparam int unsigned DmWbPtrW  = $clog2(DmWbDepth);

    typedef struct packed {
        logic [DmWbAw-3:0] wordAddr;
        logic [31:0]       data;
    } dm_wb_entry_t;

endpackage

// File: rtl/dm_wb_match.sv
// Load-address match against pending stores. Purely combinational.
// Searches from the youngest entry (tail-1) back toward the oldest, so the
// first valid match found is the youngest store to that word.
module dm_wb_match
    import dm_wb_pkg::*;
#(
    parameter int unsigned Depth = DmWbDepth,
    parameter int unsigned PtrW  = $clog2(Depth)
) (
    input  dm_wb_entry_t      entries_i [Depth],
    input  logic [Depth-1:0]  valid_i,
    input  logic [PtrW-1:0]   tail_i,
    input  logic              loadValid_i,
    input  logic [DmWbAw-3:0] loadWordAddr_i,
    output logic              hit_o,
    output logic [PtrW-1:0]   hitIdx_o,
    output logic [31:0]       hitData_o
);

    logic [PtrW-1:0] idx;

    // Youngest-first scan; the first match wins.
    always_comb begin
        hit_o     = 1'b0;
        hitIdx_o  = '0;
        hitData_o = '0;
        idx       = '0;
        for (int k = 0; k < int'(Depth); k++) begin
            idx = tail_i - PtrW'(k + 1);
            if (!hit_o && loadValid_i && valid_i[idx] &&
                entries_i[idx].wordAddr == loadWordAddr_i) begin
                hit_o     = 1'b1;
                hitIdx_o  = idx;
                hitData_o = entries_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/dm_write_buffer.sv
// Store FIFO in front of the data memory write port.
// Stores drain in program order, one per cycle when DmReady is high.
// Loads that hit a pending store stall, or with DM_WRITE_BUFFER_FWD_EN
// defined, receive the youngest matching store word instead.
// AW must not exceed dm_wb_pkg::DmWbAw (entry address field width).
module dm_write_buffer
    import dm_wb_pkg::*;
#(
    parameter int unsigned DEPTH = DmWbDepth,
    parameter int unsigned AW    = DmWbAw
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic                   StoreValid,
    input  logic [AW-1:0]          StoreAddress,
    input  logic [31:0]            StoreData,
    output logic                   StoreReady,
    input  logic                   LoadValid,
    input  logic [AW-1:0]          LoadAddress,
    output logic                   LoadStall,
    output logic                   FwdValid,
    output logic [31:0]            FwdData,
    input  logic                   DmReady,
    output logic                   WriteEnable,
    output logic [AW-1:0]          WriteAddress,
    output logic [31:0]            WriteData,
    output logic                   Empty,
    output logic [$clog2(DEPTH):0] Count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam int unsigned WaW  = AW - 2;
    localparam int unsigned EaW  = DmWbAw - 2;

    dm_wb_entry_t     entries_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PtrW-1:0]  head_q, tail_q;
    logic [CntW-1:0]  count_q;

    logic             push, pop;
    logic             hit;
    logic [PtrW-1:0]  hitIdx;
    logic [31:0]      hitData;
    logic [EaW-1:0]   loadWord;

    // Ready must not look at a same-cycle pop: no path from DmReady.
    assign StoreReady  = count_q != CntW'(DEPTH);
    assign Empty       = count_q == '0;
    assign Count       = count_q;
    assign push        = StoreValid && StoreReady;
    assign WriteEnable = !Empty && DmReady;
    assign pop         = WriteEnable;

    assign WriteAddress = Empty ? '0 : {WaW'(entries_q[head_q].wordAddr), 2'b00};
    assign WriteData    = Empty ? '0 : entries_q[head_q].data;

    assign loadWord = EaW'(LoadAddress[AW-1:2]);

    dm_wb_match #(
        .Depth (DEPTH),
        .PtrW  (PtrW)
    ) u_match (
        .entries_i      (entries_q),
        .valid_i        (valid_q),
        .tail_i         (tail_q),
        .loadValid_i    (LoadValid),
        .loadWordAddr_i (loadWord),
        .hit_o          (hit),
        .hitIdx_o       (hitIdx),
        .hitData_o      (hitData)
    );

`ifdef DM_WRITE_BUFFER_FWD_EN
    assign LoadStall = 1'b0;
    assign FwdValid  = hit;
    assign FwdData   = hitData;

    logic unusedBits;
    assign unusedBits = ^{hitIdx, StoreAddress[1:0], LoadAddress[1:0]};
`else
    // Stall holds while any matching entry remains, including one draining now.
    assign LoadStall = hit;
    assign FwdValid  = 1'b0;
    assign FwdData   = '0;

    logic unusedBits;
    assign unusedBits = ^{hitIdx, hitData, StoreAddress[1:0], LoadAddress[1:0]};
`endif

    // FIFO pointers, occupancy and valid bits; reset discards pending stores.
    always_ff @(posedge clk) begin
        if (Reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                entries_q[tail_q] <= '{wordAddr: EaW'(StoreAddress[AW-1:2]), data: StoreData};
                valid_q[tail_q]   <= 1'b1;
                tail_q            <= tail_q + PtrW'(1);
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

endmodule

// File: tb/tb_dm_write_buffer.sv
// Self-checking bench for dm_write_buffer. Expected dm writes go into a
// scoreboard queue when a store is accepted; a monitor pops and compares
// on every cycle the buffer drives WriteEnable.
module tb_dm_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
`ifdef DM_WRITE_BUFFER_FWD_EN
    localparam bit FwdEn = 1'b1;
`else
    localparam bit FwdEn = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   Reset;
    logic                   StoreValid;
    logic [AW-1:0]          StoreAddress;
    logic [31:0]            StoreData;
    logic                   StoreReady;
    logic                   LoadValid;
    logic [AW-1:0]          LoadAddress;
    logic                   LoadStall;
    logic                   FwdValid;
    logic [31:0]            FwdData;
    logic                   DmReady;
    logic                   WriteEnable;
    logic [AW-1:0]          WriteAddress;
    logic [31:0]            WriteData;
    logic                   Empty;
    logic [$clog2(DEPTH):0] Count;

    always #5 clk = ~clk;

    dm_write_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk          (clk),
        .Reset        (Reset),
        .StoreValid   (StoreValid),
        .StoreAddress (StoreAddress),
        .StoreData    (StoreData),
        .StoreReady   (StoreReady),
        .LoadValid    (LoadValid),
        .LoadAddress  (LoadAddress),
        .LoadStall    (LoadStall),
        .FwdValid     (FwdValid),
        .FwdData      (FwdData),
        .DmReady      (DmReady),
        .WriteEnable  (WriteEnable),
        .WriteAddress (WriteAddress),
        .WriteData    (WriteData),
        .Empty        (Empty),
        .Count        (Count)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] expq[$];
    int          modelCount = 0;
    logic        lastAcc;
    int          idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every dm write must match the oldest outstanding store.
    initial begin
        forever begin
            @(negedge clk);
            if (Reset === 1'b0 && WriteEnable === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected write: got addr 0x%0h data 0x%0h expected none",
                             WriteAddress, WriteData);
                end else begin
                    logic [63:0] e;
                    e = expq.pop_front();
                    check("write addr", WriteAddress, e[63:32]);
                    check("write data", WriteData, e[31:0]);
                end
            end
        end
    end

    // One clock of stimulus; checks status outputs against the occupancy model.
    task automatic cycle(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic dr, input logic lv, input logic [31:0] la,
                         input logic rst, input logic eHit, input logic [31:0] eData);
        logic acc, popE;
        StoreValid   = sv;
        StoreAddress = sa;
        StoreData    = sd;
        DmReady      = dr;
        LoadValid    = lv;
        LoadAddress  = la;
        Reset        = rst;
        @(negedge clk);
        if (!rst) begin
            check("count", 32'(Count), 32'(modelCount));
            check("store ready", 32'(StoreReady), 32'(modelCount != DEPTH));
            check("empty", 32'(Empty), 32'(modelCount == 0));
            check("write enable", 32'(WriteEnable), 32'(dr && modelCount != 0));
            check("load stall", 32'(LoadStall), 32'(!FwdEn && eHit));
            check("fwd valid", 32'(FwdValid), 32'(FwdEn && eHit));
            check("fwd data", FwdData, (FwdEn && eHit) ? eData : 32'h0);
        end
        acc  = !rst && sv && modelCount != DEPTH;
        popE = !rst && dr && modelCount != 0;
        @(posedge clk);
        #1;
        lastAcc = acc;
        if (rst) begin
            modelCount = 0;
            expq.delete();
        end else begin
            if (acc) expq.push_back({sa[31:2], 2'b00, sd});
            modelCount = modelCount + int'(acc) - int'(popE);
        end
    endtask

    task automatic idle(input logic dr);
        cycle(1'b0, 32'h0, 32'h0, dr, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic store(input logic [31:0] sa, input logic [31:0] sd, input logic dr);
        cycle(1'b1, sa, sd, dr, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic load(input logic [31:0] la, input logic dr, input logic eHit,
                        input logic [31:0] eData);
        cycle(1'b0, 32'h0, 32'h0, dr, 1'b1, la, 1'b0, eHit, eData);
    endtask

    initial begin
        // Reset, then reset-state checks on the first idle cycle.
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        idle(1'b0);

        // Single store drains the cycle after acceptance.
        store(32'h10, 32'hAAAA_0001, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Fill with dm stalled, refused fifth push, then in-order drain.
        store(32'h00, 32'hB000_0000, 1'b0);
        store(32'h04, 32'hB000_0001, 1'b0);
        store(32'h08, 32'hB000_0002, 1'b0);
        store(32'h0C, 32'hB000_0003, 1'b0);
        store(32'h50, 32'hB000_00FF, 1'b0);
        check("fifth push refused", 32'(lastAcc), 32'h0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Full with continuous pushes and pops; a refused store retries.
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            store(32'h200 + 32'(4 * idx), 32'hC000_0000 + 32'(idx), 1'b0);
            if (lastAcc) idx++;
        end
        for (int i = 0; i < 8; i++) begin
            store(32'h200 + 32'(4 * idx), 32'hC000_0000 + 32'(idx), 1'b1);
            if (lastAcc) idx++;
        end
        check("steady-state accepts", 32'(idx), 32'd11);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Two stores to one word; load hits the younger until both drain.
        store(32'h20, 32'h1, 1'b0);
        store(32'h20, 32'h2, 1'b0);
        load(32'h22, 1'b0, 1'b1, 32'h2);
        load(32'h22, 1'b1, 1'b1, 32'h2);
        load(32'h22, 1'b1, 1'b1, 32'h2);
        load(32'h22, 1'b1, 1'b0, 32'h0);

        // Miss against a different word, then a hit on the held one.
        store(32'h20, 32'h3, 1'b0);
        load(32'h40, 1'b0, 1'b0, 32'h0);
        load(32'h20, 1'b0, 1'b1, 32'h3);
        idle(1'b1);
        idle(1'b1);

        // Reset discards pending stores; none reach dm afterwards.
        store(32'h60, 32'hD000_0000, 1'b0);
        store(32'h64, 32'hD000_0001, 1'b0);
        store(32'h68, 32'hD000_0002, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        idle(1'b1);
        load(32'h64, 1'b1, 1'b0, 32'h0);
        idle(1'b1);

        check("scoreboard drained", 32'(expq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_write_buffer.md
Name: dm_write_buffer

Overview:
- Store-side FIFO directly upstream of the data memory.
- Accepts word stores from the pipeline's memory stage and drains them into the data memory write port, at most one per cycle, in program order.
- Checks every load address against pending stores so a load never returns stale memory data: it either stalls or forwards.
- Separates store issue from memory write timing and provides a drain point for later cache/bus work.

Parameters:
DEPTH, 4, number of store entries; power of two, 2..16.
AW, 32, byte-address width; word index is [AW-1:2].

Ports:
clk  input  1  system clock
Reset  input  1  synchronous active-high reset
StoreValid  input  1  pipeline presents a store this cycle
StoreAddress  input  AW  store byte address; bits [1:0] ignored
StoreData  input  32  store word
StoreReady  output  1  buffer can accept a store this cycle
LoadValid  input  1  pipeline performs a load this cycle
LoadAddress  input  AW  load byte address
LoadStall  output  1  load must hold this cycle
FwdValid  output  1  FwdData replaces memory read data this cycle
FwdData  output  32  forwarded store word
DmReady  input  1  data memory accepts a write this cycle (tie 1 for single-cycle dm)
WriteEnable  output  1  to dm WriteEnable
WriteAddress  output  AW  to dm WriteAddress
WriteData  output  32  to dm WriteData
Empty  output  1  no pending stores
Count  output  $clog2(DEPTH)+1  pending store count

Behaviour:
- Storage:
  - DEPTH-entry circular FIFO of {word address, data}.
  - Head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Count register tracks full and empty.
- Push: when StoreValid && StoreReady on rising clk, write the entry at the tail, tail+1, Count+1.
- StoreReady = (Count != DEPTH). It is not allowed to depend on a same-cycle pop, to avoid a combinational path from DmReady.
- Pop/drain:
  - WriteEnable = !Empty && DmReady.
  - WriteAddress = {head word address, 2'b00}.
  - WriteData = head data.
  - On a rising clk with WriteEnable high: head+1, Count-1.
  - When Empty, WriteAddress and WriteData drive 0.
- Simultaneous push and pop: Count unchanged; both pointers advance.
- Full, with a push attempted while a pop occurs: the push is refused because StoreReady = 0. The pipeline retries the next cycle.
- Latency: a store accepted at edge N can reach dm no earlier than the cycle after edge N (WriteEnable high in the cycle following acceptance). The buffer never bypasses the FIFO directly to dm.
- Ordering: writes reach dm strictly in acceptance order; no coalescing.
- Load hit:
  - A hit occurs when LoadValid and any valid entry's word address equals LoadAddress[AW-1:2].
  - Entries being popped this cycle still count as valid for the hit check.
  - Stores pushed in the same cycle as the load are not checked; the pipeline orders them.
- Count/Empty: Empty = (Count == 0). Count ranges 0..DEPTH.
- Reset:
  - Synchronous: on a rising clk with Reset high, head = tail = Count = 0 and all valid bits clear.
  - Pending stores are discarded, not drained.
  - Reset overrides push and pop in the same cycle.
  - After reset: StoreReady=1, Empty=1, WriteEnable=0, LoadStall=0, FwdValid=0, FwdData=0.

Optional Feature:
DM_WRITE_BUFFER_FWD_EN.
- Defined:
  - On a load hit, FwdValid=1 and FwdData = data of the youngest matching entry, searched from tail-1 back to head.
  - LoadStall=0 always.
- Undefined:
  - FwdValid=0 and FwdData=0 always.
  - LoadStall=1 on any load hit. The stall persists until every matching entry has drained.

Decomposition:
- Shared package `dm_wb_pkg`: entry typedef {word address [AW-3:0], data [31:0]}, DEPTH default, pointer-width constant.
- One natural sub-module: `dm_wb_match`, combinational. It takes the entry array, valid vector, head/tail and load word address, and returns hit, youngest hit index and hit data.
- FIFO control stays in the top.

Test Plan:
1. Reset; push 0x10/0xAAAA0001 at cycle 1 with DmReady=1 -> WriteEnable=1, WriteAddress=0x10, WriteData=0xAAAA0001 at cycle 2; Empty=1 after edge 2.
2. DmReady=0; push 4 stores (0x00,0x04,0x08,0x0C) -> StoreReady=0, Count=4. A 5th push is refused. Then DmReady=1 -> writes leave in order 0x00..0x0C on 4 consecutive cycles.
3. Fill to full, then hold StoreValid=1 and DmReady=1 -> exactly one push accepted per cycle after each pop frees space; Count stays at 3..4; no data lost, checked against a scoreboard.
4. Push 0x20/0x1 then 0x20/0x2 with DmReady=0, then load 0x22 ->
   - Macro defined: FwdValid=1, FwdData=0x2, LoadStall=0.
   - Macro undefined: LoadStall=1 until both drain, then LoadStall=0.
5. Load 0x40 with buffer holding only 0x20 -> LoadStall=0, FwdValid=0.
6. Three stores pending, assert Reset for one cycle -> next cycle Count=0, Empty=1, WriteEnable=0; none of the three addresses are written to dm.
